raymarch_pixel_scheduler: RTL and testbench
===========================================

Name: raymarch_pixel_scheduler

Overview:
Frame-level scheduler for a bank of raymarcher cores. On a frame start it hands out screen pixel coordinates in raster order to NUM_CORES cores using valid/ready dispatch. It round-robin arbitrates the cores' finished colours onto the single frame-buffer (M10K) write port. It signals frame completion once every pixel has been written back.

Parameters:
NUM_CORES, 4, number of raymarcher cores served (2..16)
SCREEN_W, 640, pixels per line
SCREEN_H, 480, lines per frame
CORDW, 10, coordinate width
COLOR_W, 10, colour width (3-4-3 RGB)
ADDR_W, 19, frame-buffer address width (must hold SCREEN_W*SCREEN_H-1)

Ports:
clk  in  1  system clock (all logic on rising edge)
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle request to render a frame
frame_busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse when the last pixel write has issued
disp_valid  out  NUM_CORES  one-hot dispatch strobe, per core
disp_ready  in  NUM_CORES  core can accept a pixel
disp_x  out  CORDW  dispatched pixel x (shared bus)
disp_y  out  CORDW  dispatched pixel y (shared bus)
res_valid  in  NUM_CORES  core holds a finished pixel
res_ready  out  NUM_CORES  one-hot result accept
res_x  in  NUM_CORES*CORDW  per-core result x, core i at [i*CORDW +: CORDW]
res_y  in  NUM_CORES*CORDW  per-core result y
res_color  in  NUM_CORES*COLOR_W  per-core result colour
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  y*SCREEN_W + x
wr_data  out  COLOR_W  colour written

Behaviour:
- Reset: FSM=IDLE; pixel counter (x,y)=(0,0); outstanding=0; both round-robin pointers=0. Outputs frame_busy=0, frame_done=0, wr_en=0, wr_addr=0, wr_data=0. disp_valid=0 and res_ready=0 during the reset cycle.
- FSM states:
  - IDLE: frame_start=1 -> DISPATCH, counters cleared, frame_busy=1 from the next cycle.
  - DISPATCH: leaves after the last pixel (SCREEN_W-1, SCREEN_H-1) is handed over -> DRAIN.
  - DRAIN: outstanding==0 and no write pending -> DONE.
  - DONE: frame_done=1 for exactly one cycle, frame_busy=0 in the same cycle -> IDLE.
- frame_start outside IDLE is ignored. It is not queued.
- Dispatch (DISPATCH only): disp_valid is combinational. At most one bit is set, granted round-robin among the cores with disp_ready=1, searching from the dispatch pointer. A transfer completes in the cycle valid&ready.
  - On a transfer: x increments. When x=SCREEN_W-1, x wraps to 0 and y increments. The pointer moves to the granted core + 1, mod NUM_CORES.
  - disp_x/disp_y always show the current counter.
- Result arbitration (every state except during reset): res_ready is combinational, one-hot round-robin among the res_valid bits, with its own pointer.
  - On accept, wr_en/wr_addr/wr_data are registered: one-cycle latency from the accept edge to wr_en high. One write per cycle at most.
  - wr_addr = res_y*SCREEN_W + res_x, computed at ADDR_W bits. The width is truncated, and inputs are never out of range.
- Outstanding counter (ADDR_W+1 bits): +1 per dispatch, -1 per result accept. A dispatch and an accept in the same cycle leave it unchanged. It never underflows. A result with outstanding==0 is a core protocol error, flagged by a bench assertion only.
- frame_done: the DRAIN->DONE check requires wr_en from the last accept to have already pulsed, so frame_done comes at least one cycle after the final wr_en.
- Reset mid-frame: immediately return to IDLE with all state cleared. Any in-flight core work is discarded; cores share the same reset.
- A single-pixel frame (SCREEN_W=SCREEN_H=1) must work: DISPATCH lasts one transfer.

Decomposition:
- Shared package raymarch_pkg holds:
  - localparams CORDW, COLOR_W, SCREEN_W, SCREEN_H, ADDR_W
  - a typedef for the scheduler FSM state (IDLE, DISPATCH, DRAIN, DONE)
  - a pixel_t struct {x, y}
- One sub-module, rr_arbiter: parameter N; inputs req[N] and advance; outputs grant[N] (one-hot). Contains the pointer, updated on advance.
- Instantiated twice: once for dispatch, once for results.

Test Plan:
- Bench config: SCREEN_W=4, SCREEN_H=2, NUM_CORES=4.
- Full frame, all cores always ready, each returns its pixel 3 cycles later:
  - 8 dispatches in raster order (0,0)..(3,1), granted to cores 0,1,2,3,0,1,2,3.
  - Exactly 8 writes at addr 0..7 with matching colours.
  - frame_done pulses once; frame_busy is low afterwards.
- Only core 2 ready:
  - all 8 pixels go to core 2, one per handshake.
  - disp_valid never asserts on another bit.
- Simultaneous results (cores 0, 1 and 3 raise res_valid in the same cycle, pointer=0):
  - res_ready grants 0, 1, 3 on consecutive cycles.
  - writes appear one cycle after each grant.
  - outstanding returns to the correct count.
- Dispatch and accept in the same cycle: outstanding stays unchanged (check the internal value, e.g. holds at 2).
- frame_start while busy: ignored, and still exactly 8 writes. Then reset asserted at dispatch #5:
  - next cycle frame_busy=0, disp_valid=0, wr_en=0.
  - a new frame_start restarts at (0,0).
- Last result held off 10 cycles in DRAIN:
  - frame_done stays low until 1+ cycles after that write.
  - no extra dispatches are issued during DRAIN.

Source files
------------

// File: rtl/raymarch_pixel_scheduler_pkg.sv
// raymarch_pkg: shared widths, screen size, scheduler state and pixel type
package raymarch_pkg;
    localparam int CORDW    = 10;
    localparam int COLOR_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} sched_state_t;

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
    } pixel_t;
endpackage

// File: rtl/raymarch_pixel_scheduler_if.sv
// raymarch_pixel_scheduler_if: dispatch, result and frame-buffer write bus between scheduler and core bank
interface raymarch_pixel_scheduler_if import raymarch_pkg::*; #(parameter int NUM_CORES = 4);
    logic [NUM_CORES-1:0]         disp_valid;
    logic [NUM_CORES-1:0]         disp_ready;
    logic [CORDW-1:0]             disp_x;
    logic [CORDW-1:0]             disp_y;
    logic [NUM_CORES-1:0]         res_valid;
    logic [NUM_CORES-1:0]         res_ready;
    logic [NUM_CORES*CORDW-1:0]   res_x;
    logic [NUM_CORES*CORDW-1:0]   res_y;
    logic [NUM_CORES*COLOR_W-1:0] res_color;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [COLOR_W-1:0]           wr_data;

    modport master (
        output disp_valid, disp_x, disp_y, res_ready, wr_en, wr_addr, wr_data,
        input  disp_ready, res_valid, res_x, res_y, res_color
    );

    modport slave (
        input  disp_valid, disp_x, disp_y, res_ready, wr_en, wr_addr, wr_data,
        output disp_ready, res_valid, res_x, res_y, res_color
    );
endinterface

// File: rtl/raymarch_pixel_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from a pointer that moves past each winner
module rr_arbiter #(parameter int N = 4) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic [PW-1:0] idx;
    logic          found;

    // first requester at or after the pointer wins; nxt is the slot just past it
    always_comb begin
        grant = '0;
        nxt   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                nxt        = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
                found      = 1'b1;
            end
        end
    end

    // pointer only moves when the granted transfer actually happens
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (advance) ptr <= nxt;
    end
endmodule

// File: rtl/raymarch_pixel_scheduler.sv
// raymarch_pixel_scheduler: raster-order pixel dispatch to cores, round-robin write-back, frame completion
module raymarch_pixel_scheduler import raymarch_pkg::*; #(
    parameter int NUM_CORES = 4,
    parameter int SCREEN_W  = raymarch_pkg::SCREEN_W,
    parameter int SCREEN_H  = raymarch_pkg::SCREEN_H
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    output logic frame_busy,
    output logic frame_done,
    raymarch_pixel_scheduler_if.master bus
);
    sched_state_t         state;
    pixel_t               pix;
    logic [ADDR_W:0]      outstanding;
    logic [NUM_CORES-1:0] disp_req, disp_gnt, res_req, res_gnt;
    logic                 disp_fire, res_acc, x_last, last_pix;
    logic [CORDW-1:0]     sel_x, sel_y;
    logic [COLOR_W-1:0]   sel_c;

    assign disp_req  = (state == DISPATCH && !reset) ? bus.disp_ready : '0;
    assign res_req   = reset ? '0 : bus.res_valid;
    assign disp_fire = |disp_gnt;
    assign res_acc   = |res_gnt;
    assign x_last    = pix.x == CORDW'(SCREEN_W - 1);
    assign last_pix  = x_last && pix.y == CORDW'(SCREEN_H - 1);

    assign bus.disp_valid = disp_gnt;
    assign bus.disp_x     = pix.x;
    assign bus.disp_y     = pix.y;
    assign bus.res_ready  = res_gnt;

    rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .clk(clk), .reset(reset), .req(disp_req), .advance(disp_fire), .grant(disp_gnt)
    );

    rr_arbiter #(.N(NUM_CORES)) u_res_arb (
        .clk(clk), .reset(reset), .req(res_req), .advance(res_acc), .grant(res_gnt)
    );

    // one-hot mux of the accepted core's result fields
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (res_gnt[i]) begin
                sel_x = bus.res_x[i*CORDW +: CORDW];
                sel_y = bus.res_y[i*CORDW +: CORDW];
                sel_c = bus.res_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // frame FSM, raster counter, in-flight count and registered frame-buffer write
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pix         <= '0;
            outstanding <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en  <= res_acc;
            frame_done <= 1'b0;
            if (res_acc) begin
                bus.wr_addr <= ADDR_W'(sel_y) * ADDR_W'(SCREEN_W) + ADDR_W'(sel_x);
                bus.wr_data <= sel_c;
            end
            if (disp_fire && !res_acc) outstanding <= outstanding + 1'b1;
            else if (res_acc && !disp_fire && outstanding != '0) outstanding <= outstanding - 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= DISPATCH;
                        pix        <= '0;
                        frame_busy <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (disp_fire) begin
                        pix.x <= x_last ? '0 : pix.x + 1'b1;
                        if (x_last) pix.y <= pix.y + 1'b1;
                        if (last_pix) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0 && !bus.wr_en && !res_acc) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raymarch_pixel_scheduler.sv
// tb_raymarch_pixel_scheduler: directed vectors with a small core-bank model on a 4x2 screen, 4 cores
module tb_raymarch_pixel_scheduler;
    import raymarch_pkg::*;

    typedef struct {
        int core;
        int x;
        int y;
        int addr;
        int color;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic frame_busy, frame_done;

    raymarch_pixel_scheduler_if #(.NUM_CORES(4)) bus ();

    raymarch_pixel_scheduler #(.NUM_CORES(4), .SCREEN_W(4), .SCREEN_H(2)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .frame_busy(frame_busy), .frame_done(frame_done), .bus(bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0, miss_cnt = 0;
    int cyc = 0;
    vec_t tab[8];
    logic [3:0] ready_mask = 4'hF, force_rv = 4'h0, dv_or;
    int lat = 3, hold_extra = 0;
    int q_x[4][8], q_y[4][8], q_due[4][8], q_h[4], q_n[4];
    int dl_core[32], dl_x[32], dl_y[32], n_d;
    int wl_addr[32], wl_data[32], wl_cyc[32], n_w;
    int al_core[32], al_cyc[32], n_a;
    int n_done, done_cyc, onehot_err, bad_state_disp;

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr();
        n_d = 0; n_w = 0; n_a = 0; n_done = 0; done_cyc = 0;
        dv_or = '0; onehot_err = 0; bad_state_disp = 0;
    endtask

    task automatic cycle(input logic fs, input logic rst_in);
        int was_out, t;
        logic fire, acc;
        @(negedge clk);
        reset = rst_in;
        frame_start = fs;
        bus.disp_ready = ready_mask;
        for (int i = 0; i < 4; i++) begin
            int h;
            h = q_h[i];
            bus.res_valid[i] = force_rv[i] | (q_n[i] > 0 && q_due[i][h] <= cyc);
            bus.res_x[i*10 +: 10] = 10'(q_x[i][h]);
            bus.res_y[i*10 +: 10] = 10'(q_y[i][h]);
            bus.res_color[i*10 +: 10] = 10'(q_x[i][h] * 3 + q_y[i][h] * 12 + 100);
        end
        #1;
        fire = 1'b0;
        acc = 1'b0;
        if (bus.wr_en) begin
            if (n_w < 32) begin
                wl_addr[n_w] = int'(bus.wr_addr);
                wl_data[n_w] = int'(bus.wr_data);
                wl_cyc[n_w] = cyc;
            end
            n_w++;
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        dv_or |= bus.disp_valid;
        if ($countones(bus.disp_valid) > 1 || $countones(bus.res_ready) > 1) onehot_err++;
        if (bus.disp_valid != '0 && dut.state != DISPATCH) bad_state_disp++;
        for (int i = 0; i < 4; i++) begin
            if (bus.disp_valid[i] && bus.disp_ready[i]) begin
                fire = 1'b1;
                if (n_d < 32) begin
                    dl_core[n_d] = i;
                    dl_x[n_d] = int'(bus.disp_x);
                    dl_y[n_d] = int'(bus.disp_y);
                end
                n_d++;
                t = (q_h[i] + q_n[i]) % 8;
                q_x[i][t] = int'(bus.disp_x);
                q_y[i][t] = int'(bus.disp_y);
                q_due[i][t] = cyc + lat + ((bus.disp_x == 3 && bus.disp_y == 1) ? hold_extra : 0);
                q_n[i]++;
            end
            if (bus.res_ready[i] && bus.res_valid[i]) begin
                acc = 1'b1;
                if (n_a < 32) begin
                    al_core[n_a] = i;
                    al_cyc[n_a] = cyc;
                end
                n_a++;
                if (q_n[i] > 0) begin
                    q_h[i] = (q_h[i] + 1) % 8;
                    q_n[i]--;
                end
            end
        end
        if (acc) assert (dut.outstanding != '0) else begin
            miss_cnt++;
            $display("FAIL protocol: result accepted with outstanding=0 (cycle %0d)", cyc);
        end
        if (rst_in) begin
            chk("rst_disp_valid", int'(bus.disp_valid), 0);
            chk("rst_res_ready", int'(bus.res_ready), 0);
        end
        was_out = int'(dut.outstanding);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_in) begin
            for (int i = 0; i < 4; i++) begin
                q_h[i] = 0;
                q_n[i] = 0;
            end
        end else if (fire && acc) chk("outstanding_hold", int'(dut.outstanding), was_out);
    endtask

    task automatic do_reset();
        force_rv = 4'hF;
        cycle(1'b0, 1'b1);
        force_rv = 4'h0;
    endtask

    task automatic run_frame(input int budget);
        int k;
        cycle(1'b1, 1'b0);
        chk("busy_after_start", int'(frame_busy), 1);
        k = 0;
        while (n_done == 0 && k < budget) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        chk("frame_done_seen", n_done, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic check_writes();
        logic [7:0] seen;
        seen = '0;
        chk("write_count", n_w, 8);
        for (int i = 0; i < n_w && i < 32; i++) begin
            chk("wr_data", wl_data[i], wl_addr[i] * 3 + 100);
            if (wl_addr[i] < 8) seen[wl_addr[i]] = 1'b1;
        end
        chk("wr_addr_cover", int'(seen), 255);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, a0, w0;
        tab[0] = '{0, 0, 0, 0, 100};
        tab[1] = '{1, 1, 0, 1, 103};
        tab[2] = '{2, 2, 0, 2, 106};
        tab[3] = '{3, 3, 0, 3, 109};
        tab[4] = '{0, 0, 1, 4, 112};
        tab[5] = '{1, 1, 1, 5, 115};
        tab[6] = '{2, 2, 1, 6, 118};
        tab[7] = '{3, 3, 1, 7, 121};
        for (int i = 0; i < 4; i++) begin
            q_h[i] = 0;
            q_n[i] = 0;
        end
        bus.disp_ready = '0;
        bus.res_valid = '0;
        bus.res_x = '0;
        bus.res_y = '0;
        bus.res_color = '0;
        clr();

        do_reset();
        chk("rst_busy", int'(frame_busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_outstanding", int'(dut.outstanding), 0);
        chk("rst_state", int'(dut.state), int'(IDLE));

        clr();
        ready_mask = 4'hF;
        lat = 3;
        run_frame(60);
        chk("dispatch_count", n_d, 8);
        for (int i = 0; i < 8; i++) begin
            chk("disp_core", dl_core[i], tab[i].core);
            chk("disp_x", dl_x[i], tab[i].x);
            chk("disp_y", dl_y[i], tab[i].y);
            chk("wr_addr", wl_addr[i], tab[i].addr);
            chk("wr_color", wl_data[i], tab[i].color);
        end
        chk("write_count", n_w, 8);
        chk("done_after_last_wr", int'(done_cyc > wl_cyc[7]), 1);
        chk("busy_after_done", int'(frame_busy), 0);
        chk("onehot", onehot_err, 0);

        do_reset();
        clr();
        ready_mask = 4'b0100;
        run_frame(60);
        chk("core2_dispatch_count", n_d, 8);
        chk("core2_valid_bits", int'(dv_or), 4);
        for (int i = 0; i < 8; i++) begin
            chk("core2_core", dl_core[i], 2);
            chk("core2_x", dl_x[i], tab[i].x);
            chk("core2_y", dl_y[i], tab[i].y);
        end
        check_writes();

        do_reset();
        clr();
        ready_mask = 4'b1011;
        lat = 1000;
        cycle(1'b1, 1'b0);
        k = 0;
        while (n_d < 3 && k < 10) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        ready_mask = 4'h0;
        chk("sim_dispatches", n_d, 3);
        chk("sim_core0", dl_core[0], 0);
        chk("sim_core1", dl_core[1], 1);
        chk("sim_core3", dl_core[2], 3);
        chk("sim_outstanding3", int'(dut.outstanding), 3);
        for (int i = 0; i < 4; i++) if (q_n[i] > 0) q_due[i][q_h[i]] = cyc;
        a0 = n_a;
        w0 = n_w;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        chk("sim_accepts", n_a - a0, 3);
        chk("sim_writes", n_w - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("sim_grant_core", al_core[a0 + i], (i == 2) ? 3 : i);
            chk("sim_grant_cycle", al_cyc[a0 + i], al_cyc[a0] + i);
            chk("sim_wr_latency", wl_cyc[w0 + i], al_cyc[a0 + i] + 1);
            chk("sim_wr_addr", wl_addr[w0 + i], i);
        end
        chk("sim_outstanding0", int'(dut.outstanding), 0);

        lat = 2;
        ready_mask = 4'b0001;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("both_outstanding2", int'(dut.outstanding), 2);
        ready_mask = 4'hF;
        k = 0;
        while (n_done == 0 && k < 60) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        chk("both_done", n_done, 1);
        chk("both_dispatch_count", n_d, 8);
        check_writes();

        do_reset();
        clr();
        lat = 3;
        cycle(1'b1, 1'b0);
        k = 0;
        while (n_done == 0 && k < 60) begin
            cycle((k == 3 || k == 10) ? 1'b1 : 1'b0, 1'b0);
            k++;
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        chk("ign_done", n_done, 1);
        chk("ign_dispatch_count", n_d, 8);
        chk("ign_busy", int'(frame_busy), 0);
        check_writes();

        clr();
        cycle(1'b1, 1'b0);
        k = 0;
        while (n_d < 4 && k < 20) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        chk("mid_dispatches", n_d, 4);
        do_reset();
        chk("mid_busy", int'(frame_busy), 0);
        chk("mid_wr_en", int'(bus.wr_en), 0);
        chk("mid_disp_valid", int'(bus.disp_valid), 0);
        chk("mid_outstanding", int'(dut.outstanding), 0);
        clr();
        run_frame(60);
        chk("restart_x", dl_x[0], 0);
        chk("restart_y", dl_y[0], 0);
        chk("restart_core", dl_core[0], 0);
        chk("restart_dispatch_count", n_d, 8);
        check_writes();

        do_reset();
        clr();
        lat = 3;
        hold_extra = 10;
        run_frame(80);
        chk("hold_dispatch_count", n_d, 8);
        chk("hold_no_drain_dispatch", bad_state_disp, 0);
        chk("hold_last_addr", wl_addr[7], 7);
        chk("hold_gap", int'(wl_cyc[7] - wl_cyc[6] >= 10), 1);
        chk("hold_done_after_wr", int'(done_cyc >= wl_cyc[7] + 1), 1);
        chk("hold_write_count", n_w, 8);
        chk("hold_onehot", onehot_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
